muu_resp_arbiter: RTL and testbench

MUU_RESP_ARBITER -- requirements
Module: muu_resp_arbiter

---
 rtl/muu_resp_arbiter.sv | 156 +++++++++++++++
 tb/tb_muu_resp_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/muu_resp_arbiter.sv
// muu_resp_arbiter: round-robin packet arbiter merging NUM_SRC response streams; optional mid-packet watchdog via MUU_RESP_ARB_WATCHDOG_EN
module muu_resp_arbiter #(
  parameter int NUM_SRC    = 2,
  parameter int DATA_WIDTH = 160,
  parameter int TIMEOUT    = 256
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_SRC*8-1:0]          in_user,
  input  logic [NUM_SRC-1:0]            in_valid,
  input  logic [NUM_SRC-1:0]            in_last,
  output logic [NUM_SRC-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [7:0]                    out_user,
  output logic                          out_valid,
  output logic                          out_last,
  input  logic                          out_ready,
  output logic [1:0]                    grant_idx,
  output logic [15:0]                   abort_count
);
  if (NUM_SRC < 2 || NUM_SRC > 4 || TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_param
    $error("muu_resp_arbiter: NUM_SRC or TIMEOUT out of range");
  end
`ifdef MUU_RESP_ARB_WATCHDOG_EN
  typedef enum logic [1:0] {ARB, XFER, ABORT} state_t;
  localparam logic [DATA_WIDTH-1:0] TERM_BEAT = DATA_WIDTH'(64'h0000_0000_FEEB_DAED);
  logic [15:0] stall;
  logic term;
`else
  typedef enum logic {ARB, XFER} state_t;
`endif
  state_t state, state_nxt;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [7:0] sel_user;
  logic sel_valid, sel_last, out_free, rdy_en, load;
  logic [1:0] grant_nxt;
  int rank, best;
  assign out_free = !out_valid || out_ready;
  // Mux the granted source and pick the next grant: lowest rank wins, rank 0 being grant_idx+1.
  always_comb begin
    sel_data = '0;
    sel_user = '0;
    sel_valid = 1'b0;
    sel_last = 1'b0;
    grant_nxt = grant_idx;
    best = NUM_SRC;
    rank = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_idx == 2'(i)) begin
        sel_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_user = in_user[i*8 +: 8];
        sel_valid = in_valid[i];
        sel_last = in_last[i];
      end
      rank = (i + 2*NUM_SRC - 1 - int'(grant_idx)) % NUM_SRC;
      if (in_valid[i] && rank < best) begin
        best = rank;
        grant_nxt = 2'(i);
      end
    end
  end
  // Next state, input acceptance and output-register load decisions.
  always_comb begin
    state_nxt = state;
    rdy_en = 1'b0;
    load = 1'b0;
`ifdef MUU_RESP_ARB_WATCHDOG_EN
    term = 1'b0;
`endif
    case (state)
      ARB: state_nxt = |in_valid ? XFER : ARB;
      XFER: begin
`ifdef MUU_RESP_ARB_WATCHDOG_EN
        if (stall >= 16'(TIMEOUT)) begin
          term = out_free;
          state_nxt = out_free ? ABORT : XFER;
        end else begin
          rdy_en = out_free;
          load = sel_valid && out_free;
          state_nxt = load && sel_last ? ARB : XFER;
        end
`else
        rdy_en = out_free;
        load = sel_valid && out_free;
        state_nxt = load && sel_last ? ARB : XFER;
`endif
      end
`ifdef MUU_RESP_ARB_WATCHDOG_EN
      ABORT: begin
        rdy_en = 1'b1;
        state_nxt = sel_valid && sel_last ? ARB : ABORT;
      end
`endif
      default: state_nxt = ARB;
    endcase
  end
  // Only the granted source sees ready; reset blocks acceptance immediately.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_SRC; i++) in_ready[i] = rdy_en && !rst && grant_idx == 2'(i);
  end
  // State register; the grant only moves when leaving ARB, so it is frozen mid-packet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ARB;
      grant_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == ARB && |in_valid) grant_idx <= grant_nxt;
    end
  end
  // Output valid/last: load on accept, clear on drain, hold while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_last <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_last <= sel_last;
`ifdef MUU_RESP_ARB_WATCHDOG_EN
    end else if (term) begin
      out_valid <= 1'b1;
      out_last <= 1'b1;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
  // Output payload; no reset needed since it is only meaningful with out_valid.
  always_ff @(posedge clk) begin
    if (load) begin
      out_data <= sel_data;
      out_user <= sel_user;
`ifdef MUU_RESP_ARB_WATCHDOG_EN
    end else if (term) begin
      out_data <= TERM_BEAT;
      out_user <= sel_user;
`endif
    end
  end
`ifdef MUU_RESP_ARB_WATCHDOG_EN
  // Stall counter: counts idle granted-source cycles, frozen while the output is back-pressured.
  always_ff @(posedge clk) begin
    if (rst || state != XFER || load) stall <= '0;
    else if (!sel_valid && out_free && stall < 16'(TIMEOUT)) stall <= stall + 16'd1;
  end
  // Saturating count of watchdog terminations.
  always_ff @(posedge clk) begin
    if (rst) abort_count <= '0;
    else if (term && abort_count != 16'hFFFF) abort_count <= abort_count + 16'd1;
  end
`else
  assign abort_count = '0;
`endif
endmodule

// File: tb/tb_muu_resp_arbiter.sv
// tb_muu_resp_arbiter: directed-vector self-checking bench for muu_resp_arbiter
module tb_muu_resp_arbiter;
  logic clk, rst, out_ready, out_valid, out_last;
  logic [319:0] in_data;
  logic [15:0] in_user;
  logic [1:0] in_valid, in_last, in_ready, grant_idx;
  logic [159:0] out_data;
  logic [7:0] out_user;
  logic [15:0] abort_count;
  int checks = 0;
  int errors = 0;
  assign in_user = {8'h22, 8'h11};
  muu_resp_arbiter #(.NUM_SRC(2), .DATA_WIDTH(160), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_user(in_user), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .out_data(out_data), .out_user(out_user),
    .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .grant_idx(grant_idx), .abort_count(abort_count));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // Beat codes: 0 idle, k beat k, -k last beat k; src1 ids are above 100, 999 is the terminator.
  function automatic int mag(int v);
    return v < 0 ? -v : v;
  endfunction
  function automatic logic [159:0] bd(int id);
    return {32'hC0DE_0000 + 32'(id), 64'h1234_5678_9ABC_DEF0, 64'(id) * 64'h0001_0001_0001_0001};
  endfunction
  function automatic logic [168:0] exp_out(int code);
    if (mag(code) == 999) return {1'b1, 8'h11, 160'h0000_0000_FEEB_DAED};
    return {code < 0, mag(code) > 100 ? 8'h22 : 8'h11, bd(mag(code))};
  endfunction
  task automatic apply(int a0, int a1, bit ord, bit r);
    rst = r;
    out_ready = ord;
    in_valid = {a1 != 0, a0 != 0};
    in_last = {a1 < 0, a0 < 0};
    in_data = {bd(mag(a1)), bd(mag(a0))};
  endtask
  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1; apply(1, 101, 1'b1, 1'b1); @(negedge clk);
      checks++; if (in_ready !== 2'b00) begin errors++; $display("FAIL reset c%0d in_ready got %b want 00", c, in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset c%0d out_valid got %b want 0", c, out_valid); end
      checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset c%0d out_last got %b want 0", c, out_last); end
      checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL reset c%0d grant_idx got %0d want 0", c, grant_idx); end
      checks++; if (abort_count !== 16'd0) begin errors++; $display("FAIL reset c%0d abort_count got %0d want 0", c, abort_count); end
    end
    @(posedge clk); #1; apply(0, 0, 1'b1, 1'b0); @(negedge clk);
    checks++; if (in_ready !== 2'b00) begin errors++; $display("FAIL reset idle in_ready got %b want 00", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset idle out_valid got %b want 0", out_valid); end
  endtask
  task automatic test_round_robin();
    int a0[10], a1[10], er[10], eg[10], eo[10];
    a0 = '{1, 1, 1, 1, 1, 1, 2, -3, 0, 0};
    a1 = '{101, 101, 102, -103, 0, 0, 0, 0, 0, 0};
    er = '{0, 2, 2, 2, 0, 1, 1, 1, 0, 0};
    eg = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    eo = '{0, 0, 101, 102, -103, 0, 1, 2, -3, 0};
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1; apply(a0[c], a1[c], 1'b1, 1'b0); @(negedge clk);
      checks++; if (in_ready !== 2'(er[c])) begin errors++; $display("FAIL rr c%0d in_ready got %b want %b", c, in_ready, 2'(er[c])); end
      checks++; if (grant_idx !== 2'(eg[c])) begin errors++; $display("FAIL rr c%0d grant_idx got %0d want %0d", c, grant_idx, eg[c]); end
      checks++; if (out_valid !== (eo[c] != 0)) begin errors++; $display("FAIL rr c%0d out_valid got %b want %b", c, out_valid, eo[c] != 0); end
      if (eo[c] != 0) begin
        checks++; if ({out_last, out_user, out_data} !== exp_out(eo[c])) begin errors++; $display("FAIL rr c%0d beat got %h want %h", c, {out_last, out_user, out_data}, exp_out(eo[c])); end
      end
    end
  endtask
  task automatic test_out_stall();
    int a0[10], ord[10], er[10], eo[10];
    a0 = '{-5, -5, -6, -6, -6, -6, -6, -6, 0, 0};
    ord = '{1, 1, 0, 0, 0, 0, 0, 1, 1, 1};
    er = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
    eo = '{0, 0, -5, -5, -5, -5, -5, -5, -6, 0};
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1; apply(a0[c], 0, ord[c] != 0, 1'b0); @(negedge clk);
      checks++; if (in_ready !== 2'(er[c])) begin errors++; $display("FAIL stall c%0d in_ready got %b want %b", c, in_ready, 2'(er[c])); end
      checks++; if (grant_idx !== 2'd0) begin errors++; $display("FAIL stall c%0d grant_idx got %0d want 0", c, grant_idx); end
      checks++; if (out_valid !== (eo[c] != 0)) begin errors++; $display("FAIL stall c%0d out_valid got %b want %b", c, out_valid, eo[c] != 0); end
      if (eo[c] != 0) begin
        checks++; if ({out_last, out_user, out_data} !== exp_out(eo[c])) begin errors++; $display("FAIL stall c%0d beat got %h want %h", c, {out_last, out_user, out_data}, exp_out(eo[c])); end
      end
    end
  endtask
  task automatic test_grant_hold();
    int a0[8], a1[8], er[8], eg[8], eo[8];
    a0 = '{0, 0, -21, -21, -21, -21, 0, 0};
    a1 = '{111, 111, 112, -113, 0, 0, 0, 0};
    er = '{0, 2, 2, 2, 0, 1, 0, 0};
    eg = '{0, 1, 1, 1, 1, 0, 0, 0};
    eo = '{0, 0, 111, 112, -113, 0, -21, 0};
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1; apply(a0[c], a1[c], 1'b1, 1'b0); @(negedge clk);
      checks++; if (in_ready !== 2'(er[c])) begin errors++; $display("FAIL hold c%0d in_ready got %b want %b", c, in_ready, 2'(er[c])); end
      checks++; if (grant_idx !== 2'(eg[c])) begin errors++; $display("FAIL hold c%0d grant_idx got %0d want %0d", c, grant_idx, eg[c]); end
      checks++; if (out_valid !== (eo[c] != 0)) begin errors++; $display("FAIL hold c%0d out_valid got %b want %b", c, out_valid, eo[c] != 0); end
      if (eo[c] != 0) begin
        checks++; if ({out_last, out_user, out_data} !== exp_out(eo[c])) begin errors++; $display("FAIL hold c%0d beat got %h want %h", c, {out_last, out_user, out_data}, exp_out(eo[c])); end
      end
    end
  endtask
  task automatic test_reset_mid_packet();
    int a1[8], r[8], er[8], eg[8], eo[8];
    a1 = '{131, 131, 132, 133, -141, -141, 0, 0};
    r = '{0, 0, 0, 1, 0, 0, 0, 0};
    er = '{0, 2, 2, 0, 0, 2, 0, 0};
    eg = '{0, 1, 1, 1, 0, 1, 1, 1};
    eo = '{0, 0, 131, 132, 0, 0, -141, 0};
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1; apply(0, a1[c], 1'b1, r[c] != 0); @(negedge clk);
      checks++; if (in_ready !== 2'(er[c])) begin errors++; $display("FAIL rstmid c%0d in_ready got %b want %b", c, in_ready, 2'(er[c])); end
      checks++; if (grant_idx !== 2'(eg[c])) begin errors++; $display("FAIL rstmid c%0d grant_idx got %0d want %0d", c, grant_idx, eg[c]); end
      checks++; if (out_valid !== (eo[c] != 0)) begin errors++; $display("FAIL rstmid c%0d out_valid got %b want %b", c, out_valid, eo[c] != 0); end
      if (eo[c] != 0) begin
        checks++; if ({out_last, out_user, out_data} !== exp_out(eo[c])) begin errors++; $display("FAIL rstmid c%0d beat got %h want %h", c, {out_last, out_user, out_data}, exp_out(eo[c])); end
      end
    end
  endtask
`ifdef MUU_RESP_ARB_WATCHDOG_EN
  task automatic test_watchdog();
    int a0[11], er[11], eg[11], eo[11];
    a0 = '{51, 51, 0, 0, 0, 0, 52, 52, -53, 0, 0};
    er = '{0, 1, 1, 1, 1, 1, 0, 1, 1, 0, 0};
    eg = '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    eo = '{0, 0, 51, 0, 0, 0, 0, -999, 0, 0, 0};
    for (int c = 0; c < 11; c++) begin
      @(posedge clk); #1; apply(a0[c], 0, 1'b1, 1'b0); @(negedge clk);
      checks++; if (in_ready !== 2'(er[c])) begin errors++; $display("FAIL wdog c%0d in_ready got %b want %b", c, in_ready, 2'(er[c])); end
      checks++; if (grant_idx !== 2'(eg[c])) begin errors++; $display("FAIL wdog c%0d grant_idx got %0d want %0d", c, grant_idx, eg[c]); end
      checks++; if (out_valid !== (eo[c] != 0)) begin errors++; $display("FAIL wdog c%0d out_valid got %b want %b", c, out_valid, eo[c] != 0); end
      checks++; if (abort_count !== 16'(c >= 7 ? 1 : 0)) begin errors++; $display("FAIL wdog c%0d abort_count got %0d want %0d", c, abort_count, c >= 7 ? 1 : 0); end
      if (eo[c] != 0) begin
        checks++; if ({out_last, out_user, out_data} !== exp_out(eo[c])) begin errors++; $display("FAIL wdog c%0d beat got %h want %h", c, {out_last, out_user, out_data}, exp_out(eo[c])); end
      end
    end
  endtask
`endif
  initial begin
    apply(0, 0, 1'b1, 1'b1);
    test_reset();
    test_round_robin();
    test_out_stall();
    test_grant_hold();
    test_reset_mid_packet();
`ifdef MUU_RESP_ARB_WATCHDOG_EN
    test_watchdog();
    checks++; if (abort_count !== 16'd1) begin errors++; $display("FAIL final abort_count got %0d want 1", abort_count); end
`else
    checks++; if (abort_count !== 16'd0) begin errors++; $display("FAIL final abort_count got %0d want 0", abort_count); end
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
